// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the register-bank write path.
//   arb_state_t  : write-arbiter FSM state (IDLE, OWNED)
//   DEF_*        : default bank geometry (DATA_W=4, ADDR_W=2, NUM_REGS=4)
//   get_slice()  : pull field idx of width w out of a flattened request bus
package reg_bank_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_t;

   localparam int DEF_DATA_W   = 4;
   localparam int DEF_ADDR_W   = 2;
   localparam int DEF_NUM_REGS = 4;

   // Flattened buses are zero-extended to this width before slicing.
   localparam int SLICE_BUS_W  = 256;

   // Returns bits [idx*w +: w] of bus, zero-extended to 32 bits (w <= 32).
   function automatic logic [31:0] get_slice(input logic [SLICE_BUS_W-1:0] bus,
                                             input int unsigned idx,
                                             input int unsigned w);
      logic [31:0] mask;
      mask = 32'hFFFF_FFFF >> (32 - w);
      return 32'(bus >> (idx * w)) & mask;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req  in  NUM_REQ  request vector
//   ptr  in  PW       highest-priority index for this cycle
//   win  out NUM_REQ  one-hot winner (all zero when req is all zero)
// Search order is ptr, ptr+1, ... NUM_REQ-1, 0, ... ptr-1.
module rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] win
);

   always_comb begin
      logic          found;
      logic [PW-1:0] idx;
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = PW'((int'(ptr) + i) % NUM_REQ);
         if (!found && req[idx]) begin
            win[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the register bank's single write path.
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   req       in   per-requester write request
//   req_lock  in   requester keeps ownership after its grant
//   req_addr  in   flattened target register, ADDR_W per requester
//   req_data  in   flattened write data, DATA_W per requester
//   gnt       out  one-hot grant pulse
//   setValue  out  one-hot register write strobe
//   valueIn   out  shared write data bus (holds last granted value)
//   owner     out  one-hot lock owner, zero when unlocked
//   addr_err  out  pulse: granted address out of range, write dropped
// All outputs are registered: request sampled at edge N shows up as
// gnt/setValue/valueIn during cycle N+1.
module reg_write_arbiter
   import reg_bank_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         req_lock,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [NUM_REGS-1:0]        setValue,
   output logic [DATA_W-1:0]          valueIn,
   output logic [NUM_REQ-1:0]         owner,
   output logic                       addr_err
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t          state;
   logic [PW-1:0]       ptr;
   logic [PW-1:0]       own_idx;

   logic [NUM_REQ-1:0]  win_oh;
   logic [PW-1:0]       win_idx;

   logic                sel_valid;
   logic [PW-1:0]       sel_idx;
   logic [NUM_REQ-1:0]  sel_oh;
   logic [PW-1:0]       nxt_ptr;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data;
   logic                addr_ok;
   logic [NUM_REGS-1:0] dec;

   logic [SLICE_BUS_W-1:0] addr_bus;
   logic [SLICE_BUS_W-1:0] data_bus;

   assign addr_bus = SLICE_BUS_W'(req_addr);
   assign data_bus = SLICE_BUS_W'(req_data);

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_pick (
      .req (req),
      .ptr (ptr),
      .win (win_oh)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (win_oh[i]) win_idx = PW'(i);
   end

   // While locked only the owner is eligible; others stay pending.
   // In OWNED the owner register is exactly the owner's one-hot.
   always_comb begin
      if (state == OWNED) begin
         sel_idx   = own_idx;
         sel_oh    = owner;
         sel_valid = req[own_idx];
      end else begin
         sel_idx   = win_idx;
         sel_oh    = win_oh;
         sel_valid = |win_oh;
      end
   end

   assign nxt_ptr  = (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + PW'(1);
   assign sel_addr = ADDR_W'(get_slice(addr_bus, 32'(sel_idx), ADDR_W));
   assign sel_data = DATA_W'(get_slice(data_bus, 32'(sel_idx), DATA_W));
   assign addr_ok  = 32'(sel_addr) < NUM_REGS;
   assign dec      = addr_ok ? (NUM_REGS'(1) << sel_addr) : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         ptr      <= '0;
         own_idx  <= '0;
         gnt      <= '0;
         setValue <= '0;
         valueIn  <= '0;
         owner    <= '0;
         addr_err <= 1'b0;
      end else begin
         gnt      <= '0;
         setValue <= '0;
         addr_err <= 1'b0;

         // valueIn follows every grant, including dropped out-of-range
         // writes; it only holds when nothing is granted.
         if (sel_valid) begin
            gnt      <= sel_oh;
            valueIn  <= sel_data;
            setValue <= dec;
            addr_err <= !addr_ok;
         end

         case (state)
            IDLE: begin
               if (sel_valid) begin
                  ptr <= nxt_ptr;
                  if (req_lock[win_idx]) begin
                     state   <= OWNED;
                     own_idx <= win_idx;
                     owner   <= win_oh;
                  end
               end
            end
            OWNED: begin
               // Lock released: leave even if a final write is granted now.
               if (!req_lock[own_idx]) begin
                  state <= IDLE;
                  owner <= '0;
                  ptr   <= nxt_ptr;
               end
            end
            default: begin
               state <= IDLE;
               owner <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the general-purpose register bank's single write path between NUM_REQ requesters, e.g. the ALU result, memory load and immediate load.
- Uses round-robin arbitration, optionally with a lock so one owner can hold the path for back-to-back writes.
- Drives one shared data bus and one write strobe (setValue) per general register.
- Sits between the execution units and the register bank; the bank registers capture on the clock edge after the strobe is issued.

Parameters:
- NUM_REQ, 3, number of write requesters (2..8).
- NUM_REGS, 4, number of general registers in the bank.
- ADDR_W, 2, register address width; must satisfy 2^ADDR_W >= NUM_REGS.
- DATA_W, 4, register data width.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester write request; held high until granted.
- req_lock  in  NUM_REQ  requester wants to keep ownership after its grant.
- req_addr  in  NUM_REQ*ADDR_W  target register per requester; requester i uses slice i.
- req_data  in  NUM_REQ*DATA_W  write data per requester; requester i uses slice i.
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: write accepted this cycle.
- setValue  out  NUM_REGS  one-hot register write strobe, active-high.
- valueIn  out  DATA_W  data bus to all registers.
- owner  out  NUM_REQ  one-hot current lock owner; all zero when unlocked.
- addr_err  out  1  one-cycle pulse: granted address >= NUM_REGS, write dropped.

Behaviour:
- Reset (reset low, asynchronous):
  - gnt, setValue, valueIn, owner and addr_err go to 0.
  - Round-robin pointer goes to 0; FSM goes to IDLE.
  - Reset mid-operation discards any pending write; no strobe is issued.
- All outputs are registered. Request sampled at edge N -> gnt/setValue/valueIn valid during cycle N+1 -> register captures at edge N+2.
- Round-robin:
  - Search starts at pointer p and goes p, p+1, ... NUM_REQ-1, 0, ...; the first requester with req high wins.
  - After a grant to requester k, p becomes (k+1) mod NUM_REQ.
  - With no requests, p is unchanged.
- Throughput: at most one grant per cycle. A requester may keep req high across consecutive cycles and is eligible again once the pointer comes back around.
- Requester protocol:
  - On seeing gnt[i], the requester either drops req[i] in that same cycle or presents the next write.
  - The arbiter samples req and data each cycle; it does not mask the cycle after a grant. A requester that leaves req high after gnt therefore requests again.
- FSM IDLE:
  - Round-robin arbitration as above.
  - If the winner k also has req_lock[k] high, go to OWNED and set owner[k] in the same cycle as gnt[k].
- FSM OWNED(k):
  - Only requester k can be granted; it is granted every cycle req[k] is high.
  - Other requests stay pending; the arbiter never drops them.
  - When req_lock[k] is low at a sampling edge, return to IDLE and clear owner. A write presented at that same edge is still granted.
  - Pointer becomes (k+1) mod NUM_REQ on exit.
- Write decode:
  - setValue[req_addr_k] = 1 and valueIn = req_data_k for exactly one cycle alongside gnt[k].
  - If req_addr_k >= NUM_REGS: gnt still pulses, setValue stays all-zero, addr_err pulses.
- Idle output: with no grant, setValue is 0 and valueIn holds its last value.
- Two requesters targeting the same register are serialized by arbitration; the later grant wins.
- Starvation bound: while unlocked, each requester holding req is granted within NUM_REQ cycles.

Decomposition:
- Shared package reg_bank_pkg holds:
  - FSM state typedef (IDLE, OWNED);
  - default widths (DATA_W=4, ADDR_W=2, NUM_REGS=4);
  - a function to extract slice i from the flattened buses.
- One sub-module rr_pick(NUM_REQ): a combinational one-hot round-robin picker taking req and pointer, returning a one-hot winner.
- Decoder and FSM stay in the top.

Test Plan:
- Reset: hold reset low with req=3'b111 -> all outputs 0, no strobe. Release reset -> first gnt=3'b001 one cycle later.
- Rotation: req=3'b111 held for 6 cycles -> gnt sequence 001,010,100,001,010,100, with setValue/valueIn matching each requester's addr/data.
- Single write: only requester 1 requests with addr=2, data=4'hA -> next cycle gnt=010, setValue=0100, valueIn=4'hA.
- Lock: requester 2 holds req+req_lock for 4 writes while requester 0 requests:
  - gnt=100 for 4 cycles and owner=100;
  - after lock drops, gnt=001 next, and the pointer returns to 0.
- Invalid address: with NUM_REGS=3, requester 0 writes addr=3 -> gnt=001, setValue=000, addr_err pulses 1 cycle.
- Async reset mid-lock: assert reset between clock edges while in OWNED -> owner and gnt clear immediately, FSM returns to IDLE, no write issued.
